// File: rtl/itlb_refill_walker.sv
// ITLB refill walker: services ITLB misses by walking a two-level Sv32-style page table.
// Optional ITLB_WALK_AD_CHECK_EN: leaf PTEs with A=0 fault instead of filling.
//
// state   | meaning
// IDLE    | ready to accept a miss
// L1_REQ  | presenting root-level PTE read
// L1_WAIT | waiting for root-level PTE
// L0_REQ  | presenting second-level PTE read
// L0_WAIT | waiting for second-level PTE
// FILL    | one-cycle ITLB write strobe
// FAULT   | one-cycle page-fault pulse
module itlb_refill_walker #(
    parameter int VADDR_WIDTH = 32,
    parameter int PADDR_WIDTH = 34,
    parameter int ITLB_ASSOC  = 8,
    parameter int PTE_WIDTH   = 32
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_miss_valid,
    input  logic [VADDR_WIDTH-1:0]        i_miss_vaddr,
    output logic                          o_miss_ready,
    input  logic [21:0]                   i_root_ppn,
    input  logic                          i_flush,
    output logic                          o_mem_req_valid,
    output logic [PADDR_WIDTH-1:0]        o_mem_req_addr,
    input  logic                          i_mem_req_ready,
    input  logic                          i_mem_resp_valid,
    input  logic [PTE_WIDTH-1:0]          i_mem_resp_data,
    output logic                          o_fill_valid,
    output logic [$clog2(ITLB_ASSOC)-1:0] o_fill_idx,
    output logic [19:0]                   o_fill_vpn,
    output logic [21:0]                   o_fill_ppn,
    output logic [7:0]                    o_fill_flags,
    output logic                          o_fill_super,
    output logic                          o_fault
);

    localparam int IDX_W = $clog2(ITLB_ASSOC);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        L1_REQ  = 3'd1,
        L1_WAIT = 3'd2,
        L0_REQ  = 3'd3,
        L0_WAIT = 3'd4,
        FILL    = 3'd5,
        FAULT   = 3'd6
    } state_t;

    state_t                 state_q, state_d;
    logic [19:0]            vpn_q;
    logic [IDX_W-1:0]       ptr_q;
    logic                   drop_q;
    logic [PADDR_WIDTH-1:0] req_addr_q;

    logic                   load_miss, load_l0, load_fill, fill_super_d;
    logic                   pte_bad, pte_leaf, pte_misaligned, pte_a_fault;
    logic [21:0]            pte_ppn;
    logic [PADDR_WIDTH-1:0] l1_addr, l0_addr;
    logic                   unused_bits;

    assign pte_ppn        = i_mem_resp_data[31:10];
    assign pte_bad        = !i_mem_resp_data[0] || (!i_mem_resp_data[1] && i_mem_resp_data[2]);
    assign pte_leaf       = i_mem_resp_data[1] || i_mem_resp_data[3];
    assign pte_misaligned = (pte_ppn[9:0] != 10'd0);

`ifdef ITLB_WALK_AD_CHECK_EN
    assign pte_a_fault = !i_mem_resp_data[6];
`else
    assign pte_a_fault = 1'b0;
`endif

    // Request addresses are captured once so they stay stable under backpressure.
    assign l1_addr = PADDR_WIDTH'({i_root_ppn, 12'h000}) + PADDR_WIDTH'({i_miss_vaddr[31:22], 2'b00});
    assign l0_addr = PADDR_WIDTH'({pte_ppn, 12'h000}) + PADDR_WIDTH'({vpn_q[9:0], 2'b00});

    assign unused_bits = ^{i_miss_vaddr[11:0], i_mem_resp_data[9:8]};

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        load_miss    = 1'b0;
        load_l0      = 1'b0;
        load_fill    = 1'b0;
        fill_super_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_miss_valid) begin
                    state_d   = L1_REQ;
                    load_miss = 1'b1;
                end
            end
            L1_REQ: begin
                if (i_flush)              state_d = IDLE;
                else if (i_mem_req_ready) state_d = L1_WAIT;
            end
            L1_WAIT: begin
                if (i_mem_resp_valid) begin
                    if (drop_q || i_flush) begin
                        state_d = IDLE;
                    end else if (pte_bad) begin
                        state_d = FAULT;
                    end else if (pte_leaf) begin
                        if (pte_misaligned || pte_a_fault) begin
                            state_d = FAULT;
                        end else begin
                            state_d      = FILL;
                            load_fill    = 1'b1;
                            fill_super_d = 1'b1;
                        end
                    end else begin
                        state_d = L0_REQ;
                        load_l0 = 1'b1;
                    end
                end
            end
            L0_REQ: begin
                if (i_flush)              state_d = IDLE;
                else if (i_mem_req_ready) state_d = L0_WAIT;
            end
            L0_WAIT: begin
                if (i_mem_resp_valid) begin
                    if (drop_q || i_flush) begin
                        state_d = IDLE;
                    end else if (pte_bad || !pte_leaf || pte_a_fault) begin
                        state_d = FAULT;
                    end else begin
                        state_d   = FILL;
                        load_fill = 1'b1;
                    end
                end
            end
            FILL:    state_d = IDLE;
            FAULT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            vpn_q        <= '0;
            ptr_q        <= '0;
            drop_q       <= 1'b0;
            req_addr_q   <= '0;
            o_fill_idx   <= '0;
            o_fill_vpn   <= '0;
            o_fill_ppn   <= '0;
            o_fill_flags <= '0;
            o_fill_super <= 1'b0;
        end else begin
            if (load_miss) begin
                vpn_q      <= i_miss_vaddr[31:12];
                req_addr_q <= l1_addr;
            end
            if (load_l0) begin
                req_addr_q <= l0_addr;
            end
            if (load_fill) begin
                o_fill_idx   <= ptr_q;
                o_fill_vpn   <= vpn_q;
                o_fill_ppn   <= pte_ppn;
                o_fill_flags <= i_mem_resp_data[7:0];
                o_fill_super <= fill_super_d;
            end
            if (state_q == FILL) begin
                ptr_q <= (ptr_q == IDX_W'(ITLB_ASSOC - 1)) ? '0 : ptr_q + IDX_W'(1);
            end
            // A flush during a wait is remembered so the late response is discarded.
            if (state_d == IDLE) begin
                drop_q <= 1'b0;
            end else if ((state_q == L1_WAIT || state_q == L0_WAIT) && i_flush) begin
                drop_q <= 1'b1;
            end
        end
    end

    assign o_miss_ready    = (state_q == IDLE);
    assign o_mem_req_valid = (state_q == L1_REQ || state_q == L0_REQ) && !i_flush;
    assign o_mem_req_addr  = req_addr_q;
    assign o_fill_valid    = (state_q == FILL);
    assign o_fault         = (state_q == FAULT);

endmodule

// File: doc/itlb_refill_walker.md
Name: itlb_refill_walker

Overview:
- Fill side of the instruction TLB: takes an ITLB miss and walks a two-level Sv32-style page table in memory.
- Writes the translated entry into a selected ITLB way, or reports a page fault.
- Sits between the fetch-stage ITLB (which holds the entries and raises misses) and the memory request port.
- Replacement way is chosen round-robin.

Parameters:
- VADDR_WIDTH, 32, virtual address width (VPN1 = [31:22], VPN0 = [21:12])
- PADDR_WIDTH, 34, physical address width of memory requests
- ITLB_ASSOC, 8, number of ITLB ways (power of two)
- PTE_WIDTH, 32, page table entry width

Ports:
- i_clk  input  1  clock
- i_rst  input  1  reset, asynchronous, active-high
- i_miss_valid  input  1  ITLB miss request
- i_miss_vaddr  input  VADDR_WIDTH  missing virtual address
- o_miss_ready  output  1  walker can accept a miss
- i_root_ppn  input  22  root page table PPN
- i_flush  input  1  abandon the current walk
- o_mem_req_valid  output  1  PTE read request
- o_mem_req_addr  output  PADDR_WIDTH  PTE byte address
- i_mem_req_ready  input  1  memory accepts the request
- i_mem_resp_valid  input  1  PTE data valid
- i_mem_resp_data  input  PTE_WIDTH  PTE
- o_fill_valid  output  1  one-cycle ITLB write strobe
- o_fill_idx  output  $clog2(ITLB_ASSOC)  way to write
- o_fill_vpn  output  20  VPN of the entry
- o_fill_ppn  output  22  PPN from the leaf PTE, unmodified
- o_fill_flags  output  8  PTE[7:0] (V R W X U G A D)
- o_fill_super  output  1  4 MiB superpage; ITLB ignores PPN[9:0]
- o_fault  output  1  one-cycle page-fault pulse

Behaviour:
- Reset (i_rst=1, async):
  - State IDLE, replacement pointer 0, drop flag 0.
  - All outputs 0 except o_miss_ready=1.
- PTE decode: V=bit0, R=1, W=2, X=3, A=6; PPN=[31:10].
- States: IDLE, L1_REQ, L1_WAIT, L0_REQ, L0_WAIT, FILL, FAULT.
- o_miss_ready is 1 only in IDLE.
- IDLE: on i_miss_valid, latch the VPN (vaddr[31:12]) and go to L1_REQ.
- L1_REQ:
  - o_mem_req_valid=1, addr = {i_root_ppn,12'b0} + VPN1*4.
  - Address and valid stay stable until i_mem_req_ready; then go to L1_WAIT.
- L1_WAIT, on i_mem_resp_valid:
  - V=0, or (R=0 and W=1): FAULT.
  - R|X=1 (leaf): if PPN[9:0]!=0 (misaligned) FAULT; else FILL with super=1.
  - Otherwise (pointer): latch PTE.PPN and go to L0_REQ.
- L0_REQ: addr = {pte_ppn,12'b0} + VPN0*4, same handshake as L1_REQ; then go to L0_WAIT.
- L0_WAIT: V=0, (R=0 and W=1), or non-leaf (R=X=0): FAULT; else FILL with super=0.
- FILL:
  - o_fill_valid=1 for exactly one cycle, o_fill_idx = pointer.
  - Pointer increments, wrapping ITLB_ASSOC-1 -> 0. Next state IDLE.
- FAULT: o_fault=1 for exactly one cycle, no fill, pointer unchanged; next state IDLE.
- Fill outputs hold their values outside the strobe; they are qualified only by o_fill_valid.
- i_mem_resp_valid is ignored outside the WAIT states. Responses may arrive the cycle after the request handshake.
- i_flush:
  - In IDLE: no effect.
  - In a REQ state before the handshake completes: go to IDLE next cycle, no request is issued.
  - In a WAIT state: set the drop flag; on the response go to IDLE with no fill and no fault.
  - In FILL or FAULT: the pulse still occurs.
- Minimum latency (ready=1, response one cycle after the request): miss accepted at T gives o_fill_valid at T+5 for a two-level walk, T+3 for a superpage.
- Address arithmetic is unsigned, PADDR_WIDTH bits, no overflow checking.

Optional Feature:
- ITLB_WALK_AD_CHECK_EN defined: a leaf with A=0 goes to FAULT; there is no hardware A-bit update.
- Undefined: the A bit is ignored and copied into o_fill_flags.

Test Plan:
- Two-level walk: root_ppn=0x00080, vaddr=0x12345678.
  - Expect L1 req addr 0x80120; respond 0x00024001.
  - Expect L0 req addr 0x90D14; respond 0x048D14CB.
  - Expect fill with vpn 0x12345, ppn 0x12345, flags 0xCB, super 0, idx 0.
- Superpage: same vaddr, L1 respond 0x0010004F -> fill with ppn 0x00400, super 1, flags 0x4F, no second request.
- Faults, each giving one o_fault pulse, no fill, and the pointer unchanged:
  - L1 response 0x00100000 (V=0).
  - L1 response 0x0010040F (misaligned superpage).
  - L0 response 0x00024001 (non-leaf).
- Replacement wrap: 9 successful walks -> o_fill_idx sequence 0..7, then 0.
- Flush:
  - i_flush in L1_WAIT, response arrives 3 cycles later -> no fill, no fault, o_miss_ready=1 the cycle after the response.
  - i_flush in L0_REQ with i_mem_req_ready=0 -> IDLE next cycle, no request is accepted.
- Reset and backpressure:
  - Assert i_rst mid-walk -> all outputs 0 and o_miss_ready=1 immediately; the next fill uses idx 0.
  - Hold i_mem_req_ready=0 for 4 cycles -> addr and valid stable until the handshake.
